// File: rtl/adpll_pkg.sv
// Shared ADPLL loop-filter types and helpers: sequencer state encoding and
// thermometer-code generation for the delay-group control word.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    TRACK
  } state_t;

  localparam int unsigned NUM_CONT_DEF = 2;
  localparam int unsigned LVL_W        = $clog2(NUM_CONT_DEF + 1);
  localparam int unsigned THERM_MAX    = 32;

  // Bit i is set when i < lvl; callers narrow the result to their group count.
  function automatic logic [THERM_MAX-1:0] therm(input int unsigned lvl,
                                                 input int unsigned num_cont);
    logic [THERM_MAX-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < THERM_MAX; i++) begin
      if ((i < num_cont) && (i < lvl)) t[i] = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/dco_settle_timer.sv
// Post-step settle timer: load clears the count, count advances it, and done
// flags the last of SETTLE_CYCLES counted cycles.
module dco_settle_timer
  import adpll_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic done
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !done) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = (cnt == CW'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/dco_tune_sequencer.sv
// ADPLL DCO loop-filter sequencer: integrates bang-bang PD decisions and steps a
// thermometer-coded delay control word one level at a time with settle waits.
module dco_tune_sequencer
  import adpll_pkg::*;
#(
  parameter int unsigned NUM_CONT      = 2,
  parameter int unsigned INIT_LEVEL    = 1,
  parameter int unsigned ACC_W         = 6,
  parameter int unsigned ACC_THRESH    = 8,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_COUNT    = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            pd_up,
  input  logic                            pd_dn,
  output logic [NUM_CONT-1:0]             lf_out,
  output logic [$clog2(NUM_CONT+1)-1:0]   level,
  output logic                            locked,
  output logic                            sat_hi,
  output logic                            sat_lo
);

  localparam int unsigned LW  = $clog2(NUM_CONT + 1);
  localparam int unsigned LCW = $clog2(LOCK_COUNT + 1);
  localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(ACC_THRESH);
  localparam logic signed [ACC_W-1:0] THR_N = -THR_P;

  state_t                   state, state_d;
  logic signed [ACC_W-1:0]  acc, acc_d, nxt, delta;
  logic [LCW-1:0]           lock_cnt, lock_cnt_d;
  logic                     locked_d;
  logic [LW-1:0]            level_d;
  logic [NUM_CONT-1:0]      lf_d;
  logic                     up_req, dn_req, step_up, step_dn;
  logic                     tmr_load, tmr_count, tmr_done;

  dco_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .rst_n(rst_n),
    .load (tmr_load),
    .count(tmr_count),
    .done (tmr_done)
  );

  // |acc| stays below ACC_THRESH, so acc+delta always fits in ACC_W bits.
  always_comb begin
    delta = '0;
    if (pd_up && !pd_dn)      delta = ACC_W'(1);
    else if (pd_dn && !pd_up) delta = '1;
    nxt     = acc + delta;
    up_req  = (nxt >= THR_P);
    dn_req  = (nxt <= THR_N);
    step_up = up_req && (level < LW'(NUM_CONT));
    step_dn = dn_req && (level != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_d = SETTLE;
        SETTLE:  if (tmr_done) state_d = TRACK;
        TRACK:   if (step_up || step_dn) state_d = SETTLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_d      = acc;
    lock_cnt_d = lock_cnt;
    locked_d   = locked;
    level_d    = level;
    tmr_load   = 1'b0;
    tmr_count  = 1'b0;
    if (!enable) begin
      acc_d      = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          acc_d      = '0;
          lock_cnt_d = '0;
          locked_d   = 1'b0;
          level_d    = LW'(INIT_LEVEL);
          tmr_load   = 1'b1;
        end
        SETTLE: begin
          tmr_count = 1'b1;
          if (tmr_done) acc_d = '0;
        end
        TRACK: begin
          if (up_req || dn_req) begin
            // Rail requests clear the integrator like a step but skip the settle.
            acc_d      = '0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            if (step_up)      level_d = level + LW'(1);
            else if (step_dn) level_d = level - LW'(1);
            tmr_load = step_up || step_dn;
          end else begin
            acc_d      = nxt;
            lock_cnt_d = (lock_cnt == LCW'(LOCK_COUNT)) ? lock_cnt : lock_cnt + LCW'(1);
            locked_d   = (lock_cnt_d == LCW'(LOCK_COUNT));
          end
        end
        default: ;
      endcase
    end
    lf_d = NUM_CONT'(therm(32'(level_d), NUM_CONT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
      level    <= LW'(INIT_LEVEL);
      lf_out   <= NUM_CONT'(therm(INIT_LEVEL, NUM_CONT));
    end else begin
      acc      <= acc_d;
      lock_cnt <= lock_cnt_d;
      locked   <= locked_d;
      level    <= level_d;
      lf_out   <= lf_d;
    end
  end

  assign sat_hi = (level == LW'(NUM_CONT));
  assign sat_lo = (level == '0);

endmodule

// File: tb/tb_dco_tune_sequencer.sv
// Directed bench for dco_tune_sequencer: a run-length vector table for the
// settle/step/rail sequence, then hand-written lock, abort and reset sequences.
module tb_dco_tune_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, enable, pd_up, pd_dn;
  logic [1:0] lf_out;
  logic [1:0] level;
  logic       locked, sat_hi, sat_lo;

  int checks = 0;
  int errors = 0;

  dco_tune_sequencer #(
    .NUM_CONT(2), .INIT_LEVEL(1), .ACC_W(6), .ACC_THRESH(8),
    .SETTLE_CYCLES(16), .LOCK_COUNT(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pd_up(pd_up), .pd_dn(pd_dn),
    .lf_out(lf_out), .level(level), .locked(locked), .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       en, up, dn;
    logic [1:0] lf, lvl;
    logic       lk, hi, lo;
    string      name;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [1:0] lf, input logic [1:0] lvl,
                     input logic lk, input logic hi, input logic lo);
    logic [6:0] act, exp;
    act = {lf_out, level, locked, sat_hi, sat_lo};
    exp = {lf, lvl, lk, hi, lo};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lf=%b lvl=%0d lk=%b hi=%b lo=%b, want lf=%b lvl=%0d lk=%b hi=%b lo=%b",
               name, lf_out, level, locked, sat_hi, sat_lo, lf, lvl, lk, hi, lo);
    end
  endtask

  task automatic run(input logic en, input logic up, input logic dn, input int n);
    enable = en; pd_up = up; pd_dn = dn;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tbl[0]  = '{1,  1'b1, 1'b0, 1'b0, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0, "enter_settle"};
    tbl[1]  = '{15, 1'b1, 1'b1, 1'b0, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0, "settle_ignores_up"};
    tbl[2]  = '{1,  1'b1, 1'b1, 1'b0, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0, "settle_done"};
    tbl[3]  = '{7,  1'b1, 1'b1, 1'b0, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0, "acc_below_thresh"};
    tbl[4]  = '{1,  1'b1, 1'b1, 1'b0, 2'b11, 2'd2, 1'b0, 1'b1, 1'b0, "step_up"};
    tbl[5]  = '{16, 1'b1, 1'b1, 1'b0, 2'b11, 2'd2, 1'b0, 1'b1, 1'b0, "post_step_settle"};
    tbl[6]  = '{7,  1'b1, 1'b1, 1'b0, 2'b11, 2'd2, 1'b0, 1'b1, 1'b0, "acc7_at_top"};
    tbl[7]  = '{1,  1'b1, 1'b1, 1'b0, 2'b11, 2'd2, 1'b0, 1'b1, 1'b0, "rail_hi"};
    tbl[8]  = '{7,  1'b1, 1'b0, 1'b1, 2'b11, 2'd2, 1'b0, 1'b1, 1'b0, "acc_neg7"};
    tbl[9]  = '{1,  1'b1, 1'b0, 1'b1, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0, "step_dn_after_rail"};
    tbl[10] = '{16, 1'b1, 1'b0, 1'b1, 2'b01, 2'd1, 1'b0, 1'b0, 1'b0, "settle_ignores_dn"};

    rst_n = 1'b0; enable = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;
    #12;
    chk("reset", 2'b01, 2'd1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run(tbl[i].en, tbl[i].up, tbl[i].dn, tbl[i].n);
      chk(tbl[i].name, tbl[i].lf, tbl[i].lvl, tbl[i].lk, tbl[i].hi, tbl[i].lo);
    end

    // Alternating up/down: net zero, lock after 32 TRACK cycles
    for (int i = 0; i < 32; i++) begin
      run(1'b1, (i % 2) == 0, (i % 2) == 1, 1);
      chk($sformatf("lock_cycle_%0d", i + 1), 2'b01, 2'd1, i == 31, 1'b0, 1'b0);
    end
    run(1'b1, 1'b0, 1'b1, 7);
    chk("lock_holds_dn7", 2'b01, 2'd1, 1'b1, 1'b0, 1'b0);
    run(1'b1, 1'b0, 1'b1, 1);
    chk("step_dn_unlock", 2'b00, 2'd0, 1'b0, 1'b0, 1'b1);

    // Abort mid-SETTLE, confirm enable low freezes the loop, then cold restart
    run(1'b1, 1'b0, 1'b1, 5);
    chk("mid_settle", 2'b00, 2'd0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b0, 1);
    chk("abort_hold", 2'b00, 2'd0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b1, 1'b0, 20);
    chk("disabled_ignores_up", 2'b00, 2'd0, 1'b0, 1'b0, 1'b1);
    run(1'b1, 1'b0, 1'b0, 1);
    chk("reenable_init", 2'b01, 2'd1, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 1'b1, 16);
    chk("reenable_settle", 2'b01, 2'd1, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 1'b1, 8);
    chk("step_to_zero", 2'b00, 2'd0, 1'b0, 1'b0, 1'b1);
    run(1'b1, 1'b0, 1'b1, 16);
    run(1'b1, 1'b0, 1'b1, 8);
    chk("rail_lo", 2'b00, 2'd0, 1'b0, 1'b0, 1'b1);

    // Both PD outputs high: zero delta, lock still builds
    run(1'b1, 1'b1, 1'b1, 31);
    chk("both_high_31", 2'b00, 2'd0, 1'b0, 1'b0, 1'b1);
    run(1'b1, 1'b1, 1'b1, 1);
    chk("both_high_lock", 2'b00, 2'd0, 1'b1, 1'b0, 1'b1);
    run(1'b1, 1'b1, 1'b1, 68);
    chk("both_high_100", 2'b00, 2'd0, 1'b1, 1'b0, 1'b1);

    // Async reset mid-TRACK with acc=5
    run(1'b1, 1'b1, 1'b0, 5);
    chk("acc5_track", 2'b00, 2'd0, 1'b1, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 2'b01, 2'd1, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    run(1'b1, 1'b1, 1'b0, 17);
    chk("restart_settle", 2'b01, 2'd1, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b1, 1'b0, 7);
    chk("restart_acc7", 2'b01, 2'd1, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b1, 1'b0, 1);
    chk("restart_step_up", 2'b11, 2'd2, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
